reg_dump_uart: RTL and testbench

Transmits a snapshot of the eight register-file byte taps (`mem0`..`mem7`) over a UART TX line as 16 uppercase ASCII hex characters followed by CR LF. It sits directly downstream of the register file and consumes its byte outputs to provide a serial debug/observation path to a host terminal. A single `start` pulse triggers one dump. Register contents are frozen at acceptance, so later register writes cannot corrupt a frame in flight.

---
 rtl/reg_dump_uart.sv | 177 +++++++++++++++++
 tb/tb_reg_dump_uart.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_uart.sv
// Purpose: dumps eight register-file byte taps as 16 uppercase hex chars + CR LF over 8N1 UART TX.
// Latency: tx drops to the start bit on the accepting edge; frame is 180*CLKS_PER_BIT cycles.
// Backpressure: none; start is honoured only in IDLE, ignored (not queued) while busy.
//
// Ports:
//   clk, rst        - single clock, synchronous active-high reset
//   start           - one-cycle (or held) dump request, sampled only when idle
//   mem0..mem7      - byte taps, mem0 is transmitted first (high nibble first)
//   tx              - UART line, idles high, LSB first
//   busy            - high for the whole 18-character frame
//   done            - one-cycle pulse at the edge that ends the final stop bit
module reg_dump_uart #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] mem0,
  input  logic [7:0] mem1,
  input  logic [7:0] mem2,
  input  logic [7:0] mem3,
  input  logic [7:0] mem4,
  input  logic [7:0] mem5,
  input  logic [7:0] mem6,
  input  logic [7:0] mem7,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [4:0]    char_q, char_d;
  logic [63:0]   snap_q, snap_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [63:0] shifted;
  logic [3:0]  nib;
  logic [7:0]  cur_char;
  logic [2:0]  bit_nxt;
  logic        baud_end;

  // Character for the current char index: byte i of the snapshot is brought
  // to the top by shifting left 8*i, then the high or low nibble is picked.
  always_comb begin
    shifted = snap_q << {char_q[3:1], 3'b000};
    nib     = char_q[0] ? shifted[59:56] : shifted[63:60];
    if (char_q == 5'd16) begin
      cur_char = 8'h0D;
    end else if (char_q == 5'd17) begin
      cur_char = 8'h0A;
    end else if (nib < 4'd10) begin
      cur_char = 8'h30 + {4'h0, nib};
    end else begin
      cur_char = 8'h37 + {4'h0, nib};
    end
  end

  assign baud_end = (baud_q == BAUD_LAST);
  assign bit_nxt  = bit_q + 3'd1;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    char_d  = char_q;
    snap_d  = snap_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Freeze the taps so later register writes cannot corrupt the frame.
          snap_d  = {mem0, mem1, mem2, mem3, mem4, mem5, mem6, mem7};
          char_d  = 5'd0;
          bit_d   = 3'd0;
          baud_d  = '0;
          state_d = START_BIT;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START_BIT: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA_BITS;
          tx_d    = cur_char[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      DATA_BITS: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = cur_char[bit_nxt];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      STOP_BIT: begin
        if (baud_end) begin
          baud_d = '0;
          if (char_q != 5'd17) begin
            // Next character starts immediately, no idle gap.
            char_d  = char_q + 5'd1;
            state_d = START_BIT;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      char_q  <= 5'd0;
      snap_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      snap_q  <= snap_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_reg_dump_uart.sv
// Purpose: self-checking bench for reg_dump_uart with CLKS_PER_BIT=4.
// Latency: model predicts tx/busy/done per cycle from a line-level bit queue.
// Backpressure: n/a; stimulus is directed, inputs driven on the falling edge.
module tb_reg_dump_uart;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] m [8];
  logic       tx, busy, done;

  int n_chk = 0;
  int n_fail = 0;

  reg_dump_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem0(m[0]), .mem1(m[1]), .mem2(m[2]), .mem3(m[3]),
    .mem4(m[4]), .mem5(m[5]), .mem6(m[6]), .mem7(m[7]),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is the text line expanded into a flat queue of line levels, one
  // entry per clock cycle; the model just plays that queue out.
  bit exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;
  bit in_frame = 1'b0;
  bit seq[$];

  function automatic string line_of(input logic [7:0] b [8]);
    string hx, s;
    hx = "0123456789ABCDEF";
    s = "";
    for (int i = 0; i < 8; i++)
      s = $sformatf("%s%c%c", s, hx[b[i][7:4]], hx[b[i][3:0]]);
    s = $sformatf("%s%c%c", s, 8'h0D, 8'h0A);
    return s;
  endfunction

  task automatic load_seq();
    string s;
    byte   c;
    s = line_of(m);
    seq.delete();
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      for (int k = 0; k < CPB; k++) seq.push_back(1'b0);
      for (int b = 0; b < 8; b++)
        for (int k = 0; k < CPB; k++) seq.push_back(c[b]);
      for (int k = 0; k < CPB; k++) seq.push_back(1'b1);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      seq.delete();
      in_frame = 1'b0;
      exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
    end else if (in_frame) begin
      if (seq.size() > 0) begin
        exp_tx = seq.pop_front(); exp_busy = 1'b1; exp_done = 1'b0;
      end else begin
        in_frame = 1'b0;
        exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b1;
      end
    end else if (start) begin
      load_seq();
      in_frame = 1'b1;
      exp_tx = seq.pop_front(); exp_busy = 1'b1; exp_done = 1'b0;
    end else begin
      exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
    end
  end

  // Cycle-by-cycle compare against the model, plus activity counters.
  int cyc = 0;
  int busy_cnt = 0;
  int done_t[$];

  always @(negedge clk) begin
    cyc++;
    chk("model_tx", {31'd0, tx}, {31'd0, exp_tx});
    chk("model_busy", {31'd0, busy}, {31'd0, exp_busy});
    chk("model_done", {31'd0, done}, {31'd0, exp_done});
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_t.push_back(cyc);
  end

  // ---------------- helpers ----------------
  bit rx_bits [180];

  // Called on a falling edge just after start is driven; samples mid-bit.
  task automatic recv_frame(input string name, output string s);
    bit   found;
    byte  c;
    int   bad;
    found = 1'b0;
    s = "";
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin found = 1'b1; break; end
    end
    if (!found) begin
      chk({name, "_start_seen"}, 32'd0, 32'd1);
      return;
    end
    repeat (CPB / 2) @(negedge clk);
    rx_bits[0] = tx;
    for (int j = 1; j < 180; j++) begin
      repeat (CPB) @(negedge clk);
      rx_bits[j] = tx;
    end
    bad = 0;
    for (int ch = 0; ch < 18; ch++) begin
      if (rx_bits[10*ch] != 1'b0 || rx_bits[10*ch+9] != 1'b1) bad++;
      for (int b = 0; b < 8; b++) c[b] = rx_bits[10*ch+1+b];
      s = $sformatf("%s%c", s, c);
    end
    chk({name, "_framing_errors"}, bad, 32'd0);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
    chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    string s;
    int b0, d0;
    logic [9:0] first10;

    for (int i = 0; i < 8; i++) m[i] = 8'h00;

    // Reset values
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("reset_tx", {31'd0, tx}, 32'd1);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
    end

    // Full frame
    m[0] = 8'h12; m[1] = 8'h34; m[2] = 8'h56; m[3] = 8'h78;
    m[4] = 8'h9A; m[5] = 8'hBC; m[6] = 8'hDE; m[7] = 8'hF0;
    b0 = busy_cnt; d0 = done_t.size();
    start = 1'b1;
    fork
      recv_frame("full", s);
      begin @(negedge clk); start = 1'b0; end
    join
    for (int j = 0; j < 10; j++) first10[9-j] = rx_bits[j];
    chk("full_first_char_bits", {22'd0, first10}, {22'd0, 10'b0100011001});
    chk_str("full_line", s, "123456789ABCDEF0\015\012");
    wait_done("full", 50);
    repeat (5) @(negedge clk);
    chk("full_busy_cycles", busy_cnt - b0, 32'd720);
    chk("full_done_count", done_t.size() - d0, 32'd1);

    // Snapshot integrity
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    start = 1'b1;
    fork
      recv_frame("snap", s);
      begin
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) m[i] = 8'hFF;
      end
    join
    chk_str("snap_line", s, "0000000000000000\015\012");
    wait_done("snap", 50);
    repeat (3) @(negedge clk);

    // Ignored start mid-frame
    m[0] = 8'h01; m[1] = 8'h23; m[2] = 8'h45; m[3] = 8'h67;
    m[4] = 8'h89; m[5] = 8'hAB; m[6] = 8'hCD; m[7] = 8'hEF;
    b0 = busy_cnt; d0 = done_t.size();
    start = 1'b1;
    fork
      recv_frame("ign", s);
      begin
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        pulse_start();
      end
    join
    chk_str("ign_line", s, "0123456789ABCDEF\015\012");
    wait_done("ign", 50);
    repeat (760) @(negedge clk);
    chk("ign_busy_cycles", busy_cnt - b0, 32'd720);
    chk("ign_done_count", done_t.size() - d0, 32'd1);

    // Reset mid-frame
    d0 = done_t.size();
    pulse_start();
    repeat (299) @(negedge clk);
    chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    start = 1'b0;
    repeat (800) @(negedge clk);
    chk("mid_no_done", done_t.size() - d0, 32'd0);
    chk("mid_idle_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) m[i] = 8'hA5;
    start = 1'b1;
    fork
      recv_frame("a5", s);
      begin @(negedge clk); start = 1'b0; end
    join
    chk_str("a5_line", s, "A5A5A5A5A5A5A5A5\015\012");
    wait_done("a5", 50);
    repeat (3) @(negedge clk);

    // Back-to-back frames with start held high
    d0 = done_t.size();
    start = 1'b1;
    wait_done("b2b_1", 800);
    chk("b2b_gap_tx", {31'd0, tx}, 32'd1);
    chk("b2b_gap_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("b2b_restart_tx", {31'd0, tx}, 32'd0);
    chk("b2b_restart_busy", {31'd0, busy}, 32'd1);
    wait_done("b2b_2", 800);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("b2b_done_count", done_t.size() - d0, 32'd2);
    if (done_t.size() - d0 >= 2)
      chk("b2b_done_spacing", done_t[d0+1] - done_t[d0], 32'd721);
    chk("b2b_final_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
